gate_tt_sequencer: RTL and testbench
====================================

# gate_tt_sequencer

Self-checking truth-table controller for a 2-input combinational gate under test (OR by default). On `start` it drives the four input vectors onto the gate in order, waits a programmable settle time for each, and samples the gate output. It compares each sample against an expected truth table and reports pass/fail, a per-vector fail mask and an error count. It sits between a host/test harness and any 2-input gate instance, replacing hand-written stimulus sequences.

## Interface

- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling; legal range 0..15.
- `EXPECTED`, default 4'b1110: expected gate output, bit index = {A,B}; default is OR.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; accepted only in IDLE.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `gate_a`  out  1  gate input A.
- `gate_b`  out  1  gate input B.
- `gate_c`  in  1  gate output C.
- `pass`  out  1  1 if the last completed run had zero mismatches.
- `err_count`  out  3  mismatch count of the last run, 0..4.
- `fail_mask`  out  4  bit i set if the vector {A,B}=i mismatched.
- `result_vec`  out  4  captured `gate_c` per vector, bit i = sample for {A,B}=i.

## Operation

- Reset values: state IDLE; `busy`, `done`, `pass`, `gate_a`, `gate_b` = 0; `err_count` = 0; `fail_mask` = 0000; `result_vec` = 0000.
- States: IDLE, SETTLE, SAMPLE.
- IDLE: `gate_a`/`gate_b` = 0.
  - When `start`=1 at an edge: clear `err_count`, `fail_mask`, `result_vec` and `pass`; set idx=0; drive {A,B}=00; go to SETTLE; `busy`=1.
- SETTLE: hold the vector while the settle counter counts SETTLE_CYCLES cycles, then go to SAMPLE. If SETTLE_CYCLES=0, the settle phase takes zero cycles: the next edge after entry is the sample edge.
- SAMPLE edge:
  - Write `result_vec[idx]` = `gate_c`.
  - On mismatch against `EXPECTED[idx]`: set `fail_mask[idx]` and increment `err_count`.
  - If idx<3: idx+1, drive the next vector, return to SETTLE.
  - If idx=3: go to IDLE, drive `gate_a`/`gate_b` = 0, `busy`=0, `done`=1 for one cycle, and `pass` = (final `err_count`==0).
- Vector order: 00, 01, 10, 11 ({A,B}).
- `start` while busy: ignored, no effect on the run.
- `start` high during the `done` cycle is accepted, so back-to-back runs are allowed.
- Results (`pass`, `err_count`, `fail_mask`, `result_vec`) hold until the next accepted `start` or reset.
- Reset mid-run: immediate return to reset values; no `done` is issued; the partial results are discarded.
- `err_count` cannot overflow (at most 4).

## Timing

- Each vector is driven for exactly SETTLE_CYCLES+1 cycles.
- `gate_c` is sampled at the edge that ends the vector's last cycle.
- Latency: `done` is high in the cycle beginning 4·(SETTLE_CYCLES+1) edges after the start-accept edge. With the default this is 12 edges.
- `busy` rises at the accept edge and falls at the same edge `done` rises.
- `gate_c` is treated as combinational from `gate_a`/`gate_b`. A gate with register delay d needs SETTLE_CYCLES ≥ d to pass.
- All outputs are registered.

## Test plan

- Ideal OR model, defaults; pulse `start`.
  - A/B step through 00, 01, 10, 11 for 3 cycles each.
  - `done` appears 12 edges after the accept edge.
  - Required: `pass`=1, `err_count`=0, `fail_mask`=0000, `result_vec`=1110.
- `gate_c` stuck at 0.
  - Required: `result_vec`=0000, `fail_mask`=1110, `err_count`=3, `pass`=0.
- AND model in place of OR.
  - Required: `result_vec`=1000, `fail_mask`=0110, `err_count`=2, `pass`=0.
- `start` re-pulsed mid-run: ignored, and `done` timing is unchanged.
- `start` held high continuously: the second run is accepted in the `done` cycle, results are cleared at that edge, and the second `done` follows 12 edges later.
- Reset asserted while vector 10 is driven: all outputs at reset values at once; no `done`. A new `start` then gives a clean full run with `pass`=1.
- SETTLE_CYCLES=0 with a 1-cycle registered OR model (register resets to 0).
  - `done` 4 edges after accept.
  - Required: `result_vec`=1100, `fail_mask`=0010, `err_count`=1, `pass`=0.
  - With SETTLE_CYCLES=1 the same model gives `pass`=1.

Source files
------------

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate under test.
// Steps {A,B} through 00..11, settles, samples C and scores it.
module gate_tt_sequencer #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [3:0] result_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_e;

  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [3:0] SETTLE_LAST =
    NO_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam state_e FIRST_ST =
    NO_SETTLE ? SAMPLE : SETTLE;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic [3:0] res_q, res_d;
  logic       miss;
  logic [1:0] idx_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    res_d    = res_q;
    miss     = gate_c != EXPECTED[idx_q];
    idx_n    = idx_q + 2'd1;

    case (state_q)
      IDLE: begin
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
        if (start) begin
          err_d   = 3'd0;
          fail_d  = 4'd0;
          res_d   = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = FIRST_ST;
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SAMPLE: begin
        res_d[idx_q] = gate_c;
        if (miss) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          // last vector scored: release the gate and report
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (err_d == 3'd0);
          state_d  = IDLE;
        end else begin
          idx_d    = idx_n;
          gate_a_d = idx_n[1];
          gate_b_d = idx_n[0];
          cnt_d    = 4'd0;
          state_d  = FIRST_ST;
        end
      end

      default: begin
        state_d  = IDLE;
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 2'd0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= 4'd0;
      res_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      res_q    <= res_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign gate_a     = gate_a_q;
  assign gate_b     = gate_b_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_mask  = fail_q;
  assign result_vec = res_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: three instances (settle 2/0/1)
// checked every cycle against a time-based model plus literals.
module tb_gate_tt_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  int   mode;

  always #5 clk = ~clk;

  logic [2:0] busy_w, done_w, a_w, b_w, pass_w;
  logic [2:0] err_w  [3];
  logic [3:0] fail_w [3];
  logic [3:0] res_w  [3];
  logic       c0, c1, c2;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] EXP = 4'b1110;

  gate_tt_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_w[0]), .done(done_w[0]),
    .gate_a(a_w[0]), .gate_b(b_w[0]), .gate_c(c0),
    .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_mask(fail_w[0]), .result_vec(res_w[0])
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_w[1]), .done(done_w[1]),
    .gate_a(a_w[1]), .gate_b(b_w[1]), .gate_c(c1),
    .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_mask(fail_w[1]), .result_vec(res_w[1])
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy_w[2]), .done(done_w[2]),
    .gate_a(a_w[2]), .gate_b(b_w[2]), .gate_c(c2),
    .pass(pass_w[2]), .err_count(err_w[2]),
    .fail_mask(fail_w[2]), .result_vec(res_w[2])
  );

  // gate models: 0 OR, 1 stuck-at-0, 2 AND
  function automatic logic gfun(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] | v[0];
      1:       return 1'b0;
      default: return v[1] & v[0];
    endcase
  endfunction

  assign c0 = gfun(mode, {a_w[0], b_w[0]});

  // one-cycle registered OR gates for the short-settle instances
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= 1'b0;
      c2 <= 1'b0;
    end else begin
      c1 <= a_w[1] | b_w[1];
      c2 <= a_w[2] | b_w[2];
    end
  end

  function automatic int sv(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  // model: elapsed cycles since accept decide vector and sample points
  int         mk    [3];
  bit         mrun  [3];
  bit         mdone [3];
  bit         mpass [3];
  int         merr  [3];
  logic [3:0] mres  [3];
  logic [3:0] mfail [3];
  logic [1:0] mprev [3];

  function automatic logic [1:0] mvec(input int d);
    int v;
    v = mk[d] / (sv(d) + 1);
    return mrun[d] ? 2'(v) : 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        mk[d]    <= 0;
        mrun[d]  <= 1'b0;
        mdone[d] <= 1'b0;
        mpass[d] <= 1'b0;
        merr[d]  <= 0;
        mres[d]  <= 4'd0;
        mfail[d] <= 4'd0;
        mprev[d] <= 2'd0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        automatic logic [1:0] cur = mvec(d);
        automatic logic smp = (d == 0) ? gfun(mode, cur)
                                       : (mprev[d][1] | mprev[d][0]);
        automatic int k = mk[d];
        automatic int er = merr[d];
        automatic bit run = mrun[d];
        automatic bit dn = 1'b0;
        automatic bit ps = mpass[d];
        automatic logic [3:0] r = mres[d];
        automatic logic [3:0] f = mfail[d];
        if (run) begin
          if ((k + 1) % (sv(d) + 1) == 0) begin
            r[cur] = smp;
            if (smp != EXP[cur]) begin
              f[cur] = 1'b1;
              er = er + 1;
            end
            if (cur == 2'd3) begin
              run = 1'b0;
              dn  = 1'b1;
              ps  = (er == 0);
            end
          end
          k = k + 1;
        end else if (start) begin
          run = 1'b1;
          k   = 0;
          r   = 4'd0;
          f   = 4'd0;
          er  = 0;
          ps  = 1'b0;
        end
        mk[d]    <= k;
        mrun[d]  <= run;
        mdone[d] <= dn;
        mpass[d] <= ps;
        merr[d]  <= er;
        mres[d]  <= r;
        mfail[d] <= f;
        mprev[d] <= cur;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        automatic logic [1:0] v = mvec(d);
        chk($sformatf("busy%0d", d), int'(busy_w[d]), int'(mrun[d]));
        chk($sformatf("done%0d", d), int'(done_w[d]), int'(mdone[d]));
        chk($sformatf("gate_a%0d", d), int'(a_w[d]), int'(v[1]));
        chk($sformatf("gate_b%0d", d), int'(b_w[d]), int'(v[0]));
        chk($sformatf("pass%0d", d), int'(pass_w[d]), int'(mpass[d]));
        chk($sformatf("err%0d", d), int'(err_w[d]), merr[d]);
        chk($sformatf("fail%0d", d), int'(fail_w[d]), int'(mfail[d]));
        chk($sformatf("res%0d", d), int'(res_w[d]), int'(mres[d]));
      end
    end
  end

  task automatic pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int d, output int n);
    n = 0;
    while (!done_w[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_res(input string t, input int d, input int ps,
                         input int er, input int fm, input int rv);
    chk({t, "_pass"}, int'(pass_w[d]), ps);
    chk({t, "_err"}, int'(err_w[d]), er);
    chk({t, "_fail"}, int'(fail_w[d]), fm);
    chk({t, "_res"}, int'(res_w[d]), rv);
  endtask

  task automatic chk_zero(input string t, input int d);
    chk({t, "_busy"}, int'(busy_w[d]), 0);
    chk({t, "_done"}, int'(done_w[d]), 0);
    chk({t, "_a"}, int'(a_w[d]), 0);
    chk({t, "_b"}, int'(b_w[d]), 0);
    chk_res(t, d, 0, 0, 0, 0);
  endtask

  initial begin
    int n, m, nd;
    mode  = 0;
    start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_zero($sformatf("rst%0d", d), d);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ideal OR, all three settle settings
    pulse();
    wait_done(1, n);
    chk("lat_s0", n, 4);
    wait_done(0, m);
    chk("lat_or", n + m, 12);
    chk_res("or", 0, 1, 0, 4'b0000, 4'b1110);
    chk_res("reg_s0", 1, 0, 1, 4'b0010, 4'b1100);
    chk_res("reg_s1", 2, 1, 0, 4'b0000, 4'b1110);
    repeat (3) @(negedge clk);

    mode = 1;
    pulse();
    wait_done(0, n);
    chk("lat_st0", n, 12);
    chk_res("stuck0", 0, 0, 3, 4'b1110, 4'b0000);
    repeat (3) @(negedge clk);

    mode = 2;
    pulse();
    wait_done(0, n);
    chk_res("and", 0, 0, 2, 4'b0110, 4'b1000);
    repeat (3) @(negedge clk);

    // start re-pulsed mid-run
    mode = 0;
    pulse();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(0, n);
    chk("lat_repulse", n + 4, 12);
    chk("repulse_pass", int'(pass_w[0]), 1);
    repeat (3) @(negedge clk);

    // start held: back-to-back runs
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done(0, n);
    chk("lat_hold1", n, 12);
    @(negedge clk);
    chk("hold_busy", int'(busy_w[0]), 1);
    chk("hold_clr_res", int'(res_w[0]), 0);
    chk("hold_clr_pass", int'(pass_w[0]), 0);
    wait_done(0, m);
    chk("lat_hold2", m, 12);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // reset while vector 10 is driven
    pulse();
    n = 0;
    while (!(a_w[0] && !b_w[0]) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("v10_seen", int'(a_w[0] & ~b_w[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst", 0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0]) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    pulse();
    wait_done(0, n);
    chk("lat_after_rst", n, 12);
    chk_res("after_rst", 0, 1, 0, 4'b0000, 4'b1110);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
